muldiv_unit: RTL and testbench

Iterative RV32M multiply/divide unit. It sits directly downstream of the register file read ports and upstream of its write port. It consumes `rs1_data`/`rs2_data` for M-extension instructions and returns a 32-bit result plus destination register for write-back. It executes all eight RV32M operations with a fixed 33-cycle latency, using one shared 32-iteration shift datapath and a start/busy/done handshake to stall the core.

---
 rtl/rv32_pkg.sv | 25 ++
 rtl/muldiv_unit.sv | 184 ++++++++++++++++++
 tb/tb_muldiv_unit.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/rv32_pkg.sv
// rtl/rv32_pkg.sv - RV32M funct3 codes, FSM state type and shared helpers
package rv32_pkg;

  localparam int XLEN = 32;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIN  = 2'd2
  } state_t;

  function automatic logic [XLEN-1:0] twos_neg(input logic [XLEN-1:0] v);
    return ~v + {{(XLEN-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative RV32M multiply/divide, fixed 33-cycle latency
// One 64-bit {hi, lo} shift register and one 33-bit adder serve both multiply and divide.
module muldiv_unit
  import rv32_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [2:0]       i_funct3,
  input  logic [XLEN-1:0]  i_rs1_data,
  input  logic [XLEN-1:0]  i_rs2_data,
  input  logic [4:0]       i_rd_addr_in,
  output logic             o_busy,
  output logic             o_done,
  output logic [4:0]       o_rd_addr,
  output logic [XLEN-1:0]  o_result
);

  state_t            r_state;
  state_t            w_next;
  logic [4:0]        r_cnt;
  logic [2:0]        r_f3;
  logic [4:0]        r_rd;
  logic [XLEN-1:0]   r_opb;
  logic [XLEN-1:0]   r_hi;
  logic [XLEN-1:0]   r_lo;
  logic [XLEN-1:0]   r_rs1;
  logic              r_neg;
  logic              r_div0;
  logic              r_ovf;
  logic [XLEN-1:0]   r_result;
  logic              r_done;

  logic              w_sa;
  logic              w_sb;
  logic              w_a_neg;
  logic              w_b_neg;
  logic [XLEN-1:0]   w_a_mag;
  logic [XLEN-1:0]   w_b_mag;
  logic              w_neg_in;
  logic              w_div0_in;
  logic              w_ovf_in;

  logic              w_div_mode;
  logic [XLEN:0]     w_add_a;
  logic [XLEN:0]     w_add_b;
  logic [XLEN+1:0]   w_sum;

  logic [2*XLEN-1:0] w_prod;
  logic [2*XLEN-1:0] w_prod_s;
  logic [XLEN-1:0]   w_quo_s;
  logic [XLEN-1:0]   w_rem_s;
  logic [XLEN-1:0]   w_fin;

  // Operand decode, only meaningful in the accept cycle
  always_comb begin
    w_sa      = (i_funct3 == F3_MULH) || (i_funct3 == F3_MULHSU) ||
                (i_funct3 == F3_DIV)  || (i_funct3 == F3_REM);
    w_sb      = (i_funct3 == F3_MULH) || (i_funct3 == F3_DIV) || (i_funct3 == F3_REM);
    w_a_neg   = w_sa & i_rs1_data[XLEN-1];
    w_b_neg   = w_sb & i_rs2_data[XLEN-1];
    w_a_mag   = w_a_neg ? twos_neg(i_rs1_data) : i_rs1_data;
    w_b_mag   = w_b_neg ? twos_neg(i_rs2_data) : i_rs2_data;
    w_neg_in  = (i_funct3 == F3_REM) ? w_a_neg : (w_a_neg ^ w_b_neg);
    w_div0_in = (i_rs2_data == '0);
    w_ovf_in  = ((i_funct3 == F3_DIV) || (i_funct3 == F3_REM)) &&
                (i_rs1_data == 32'h8000_0000) && (i_rs2_data == 32'hFFFF_FFFF);
  end

  // Multiply adds the multiplicand into hi; divide subtracts the divisor
  // from {hi, next dividend bit}. Carry-out of a subtract means no borrow.
  always_comb begin
    w_div_mode = r_f3[2];
    w_add_a    = w_div_mode ? {r_hi, r_lo[XLEN-1]} : {1'b0, r_hi};
    w_add_b    = {1'b0, r_opb};
    w_sum      = {1'b0, w_add_a}
               + {1'b0, (w_div_mode ? ~w_add_b : w_add_b)}
               + {{(XLEN+1){1'b0}}, w_div_mode};
  end

  always_comb begin
    w_prod   = {r_hi, r_lo};
    w_prod_s = r_neg ? (~w_prod + 64'd1) : w_prod;
    w_quo_s  = r_neg ? twos_neg(r_lo) : r_lo;
    w_rem_s  = r_neg ? twos_neg(r_hi) : r_hi;
    w_fin    = '0;
    case (r_f3)
      F3_MUL:                         w_fin = w_prod_s[XLEN-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU:   w_fin = w_prod_s[2*XLEN-1:XLEN];
      F3_DIV, F3_DIVU: begin
        if (r_div0)     w_fin = '1;
        else if (r_ovf) w_fin = 32'h8000_0000;
        else            w_fin = w_quo_s;
      end
      default: begin
        if (r_div0)     w_fin = r_rs1;
        else if (r_ovf) w_fin = '0;
        else            w_fin = w_rem_s;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (i_start) w_next = ST_CALC;
      ST_CALC: if (r_cnt == 5'd31) w_next = ST_FIN;
      ST_FIN:  w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    o_busy = (r_state == ST_CALC) || (r_state == ST_FIN);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt    <= '0;
      r_f3     <= '0;
      r_rd     <= '0;
      r_opb    <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_rs1    <= '0;
      r_neg    <= 1'b0;
      r_div0   <= 1'b0;
      r_ovf    <= 1'b0;
      r_result <= '0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_cnt  <= '0;
            r_f3   <= i_funct3;
            r_rd   <= i_rd_addr_in;
            r_opb  <= w_b_mag;
            r_hi   <= '0;
            r_lo   <= w_a_mag;
            r_rs1  <= i_rs1_data;
            r_neg  <= w_neg_in;
            r_div0 <= w_div0_in;
            r_ovf  <= w_ovf_in;
          end
        end
        ST_CALC: begin
          r_cnt <= r_cnt + 5'd1;
          if (w_div_mode) begin
            if (w_sum[XLEN+1]) begin
              r_hi <= w_sum[XLEN-1:0];
              r_lo <= {r_lo[XLEN-2:0], 1'b1};
            end else begin
              r_hi <= w_add_a[XLEN-1:0];
              r_lo <= {r_lo[XLEN-2:0], 1'b0};
            end
          end else if (r_lo[0]) begin
            r_hi <= w_sum[XLEN:1];
            r_lo <= {w_sum[0], r_lo[XLEN-1:1]};
          end else begin
            r_hi <= {1'b0, r_hi[XLEN-1:1]};
            r_lo <= {r_hi[0], r_lo[XLEN-1:1]};
          end
        end
        ST_FIN: begin
          r_result <= w_fin;
          r_done   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign o_done    = r_done;
  assign o_result  = r_result;
  assign o_rd_addr = r_rd;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - directed-vector self-checking bench for muldiv_unit
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  funct3 = 3'd0;
  logic [31:0] rs1_data = 32'd0;
  logic [31:0] rs2_data = 32'd0;
  logic [4:0]  rd_addr_in = 5'd0;
  logic        busy;
  logic        done;
  logic [4:0]  rd_addr;
  logic [31:0] result;

  int n_checks = 0;
  int n_errors = 0;

  muldiv_unit dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_start      (start),
    .i_funct3     (funct3),
    .i_rs1_data   (rs1_data),
    .i_rs2_data   (rs2_data),
    .i_rd_addr_in (rd_addr_in),
    .o_busy       (busy),
    .o_done       (done),
    .o_rd_addr    (rd_addr),
    .o_result     (result)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Issues one op; returns edges from accept to the first sample with done=1.
  // On return the bench sits #1 after the edge that raised done.
  task automatic run_op(input bit aligned, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd, output int lat);
    if (aligned) @(negedge clk);
    funct3 = f3; rs1_data = a; rs2_data = b; rd_addr_in = rd; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    lat = 0;
    while (!done && lat < 60) begin
      @(posedge clk);
      #1 lat++;
    end
  endtask

  typedef struct {
    string       tag;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[$];

  initial begin
    int lat;
    int lat2;
    int done_seen;

    vecs.push_back('{"mul_7x-3",      3'b000, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB});
    vecs.push_back('{"mulh_7x-3",     3'b001, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFFF});
    vecs.push_back('{"mulhu_max",     3'b011, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE});
    vecs.push_back('{"mulhsu_-1",     3'b010, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF});
    vecs.push_back('{"div_-7/2",      3'b100, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD});
    vecs.push_back('{"rem_-7/2",      3'b110, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF});
    vecs.push_back('{"divu_100/7",    3'b101, 32'd100,        32'd7,         32'd14});
    vecs.push_back('{"remu_100/7",    3'b111, 32'd100,        32'd7,         32'd2});
    vecs.push_back('{"div_5/0",       3'b100, 32'd5,          32'd0,         32'hFFFF_FFFF});
    vecs.push_back('{"rem_5/0",       3'b110, 32'd5,          32'd0,         32'd5});
    vecs.push_back('{"divu_5/0",      3'b101, 32'd5,          32'd0,         32'hFFFF_FFFF});
    vecs.push_back('{"remu_-9/0",     3'b111, 32'hFFFF_FFF7,  32'd0,         32'hFFFF_FFF7});
    vecs.push_back('{"div_ovf",       3'b100, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000});
    vecs.push_back('{"rem_ovf",       3'b110, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0});
    vecs.push_back('{"mul_-5x-6",     3'b000, 32'hFFFF_FFFB,  32'hFFFF_FFFA, 32'd30});
    vecs.push_back('{"rem_7/-2",      3'b110, 32'd7,          32'hFFFF_FFFE, 32'd1});

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_busy",   {31'd0, busy}, 32'd0);
    check("rst_done",   {31'd0, done}, 32'd0);
    check("rst_result", result,        32'd0);
    check("rst_rd",     {27'd0, rd_addr}, 32'd0);

    foreach (vecs[i]) begin
      run_op(1'b1, vecs[i].f3, vecs[i].a, vecs[i].b, 5'(i + 1), lat);
      check({vecs[i].tag, "_lat"}, lat, 33);
      check(vecs[i].tag, result, vecs[i].exp);
      check({vecs[i].tag, "_rd"}, {27'd0, rd_addr}, 32'(i + 1));
      check({vecs[i].tag, "_busy_in_done"}, {31'd0, busy}, 32'd0);
      @(posedge clk);
      #1 check({vecs[i].tag, "_done_1cyc"}, {31'd0, done}, 32'd0);
    end

    // start while busy must be ignored
    @(negedge clk);
    funct3 = 3'b101; rs1_data = 32'd100; rs2_data = 32'd7; rd_addr_in = 5'd5; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    check("busy_after_accept", {31'd0, busy}, 32'd1);
    repeat (5) @(posedge clk);
    #1 begin
      funct3 = 3'b000; rs1_data = 32'd9; rs2_data = 32'd9; rd_addr_in = 5'd9; start = 1'b1;
    end
    @(posedge clk);
    #1 start = 1'b0;
    lat = 6;
    while (!done && lat < 60) begin
      @(posedge clk);
      #1 lat++;
    end
    check("ignore_lat",    lat, 33);
    check("ignore_result", result, 32'd14);
    check("ignore_rd",     {27'd0, rd_addr}, 32'd5);

    // back-to-back: start raised in the done cycle
    run_op(1'b1, 3'b000, 32'd6, 32'd7, 5'd3, lat);
    check("b2b_first", result, 32'd42);
    run_op(1'b0, 3'b101, 32'd50, 32'd5, 5'd4, lat2);
    check("b2b_gap",    lat2 + 1, 34);
    check("b2b_second", result, 32'd10);
    check("b2b_rd",     {27'd0, rd_addr}, 32'd4);

    // reset during CALC
    @(negedge clk);
    funct3 = 3'b000; rs1_data = 32'd11; rs2_data = 32'd13; rd_addr_in = 5'd7; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    check("rstmid_busy",   {31'd0, busy}, 32'd0);
    check("rstmid_result", result, 32'd0);
    check("rstmid_rd",     {27'd0, rd_addr}, 32'd0);
    done_seen = 0;
    repeat (40) begin
      @(posedge clk);
      #1 if (done) done_seen++;
    end
    check("rstmid_no_done", done_seen, 0);
    run_op(1'b1, 3'b000, 32'd3, 32'd4, 5'd1, lat);
    check("post_rst_lat", lat, 33);
    check("post_rst_mul", result, 32'd12);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
